// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite responder over a word SRAM: write commits one edge after AW+W, read data one edge after AR.
// Bready/Rready low holds the response and blocks new transactions on that channel only.
module axi4lite_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] AWdata,
  input  logic        AWvalid,
  output logic        AWready,
  input  logic [2:0]  AWprot,
  input  logic [31:0] Wdata,
  input  logic [3:0]  Wstrb,
  input  logic        Wvalid,
  output logic        Wready,
  output logic        Bvalid,
  input  logic        Bready,
  input  logic [31:0] ARdata,
  input  logic        ARvalid,
  output logic        ARready,
  input  logic [2:0]  ARprot,
  output logic [31:0] Rdata,
  output logic        Rvalid,
  input  logic        Rready,
  output logic        err
);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_t;

  logic [31:0] mem [DEPTH];

  w_state_t    w_state, w_next;
  r_state_t    r_state, r_next;
  logic [31:0] awaddr_q, wdata_q, araddr_q;
  logic [3:0]  wstrb_q;
  logic        aw_hs, w_hs, ar_hs, b_hs;
  logic        wr_commit, rd_fetch, wr_in_range, rd_in_range;
  logic [IW-1:0] wr_idx, rd_idx;
  logic        unused_bits;

  // BASE_ADDR is aligned to the SRAM size, so decode is a compare of the bits above the index.
  function automatic logic in_range(input logic [31:0] a);
    return a[31:IW+2] == BASE_ADDR[31:IW+2];
  endfunction

  assign Bvalid  = (w_state == W_RESP);
  assign Rvalid  = (r_state == R_RESP);
  assign ARready = (r_state == R_IDLE);

  assign aw_hs = AWvalid && AWready;
  assign w_hs  = Wvalid && Wready;
  assign ar_hs = ARvalid && ARready;
  assign b_hs  = Bvalid && Bready;

  // Both halves are latched once the ready for the later one has also dropped.
  assign wr_commit = ((w_state == W_HAVE_A) && !Wready) || ((w_state == W_HAVE_D) && !AWready);
  assign rd_fetch  = (r_state == R_FETCH);

  assign wr_in_range = in_range(awaddr_q);
  assign rd_in_range = in_range(araddr_q);
  assign wr_idx      = awaddr_q[IW+1:2];
  assign rd_idx      = araddr_q[IW+1:2];
  assign unused_bits = ^{AWprot, ARprot, awaddr_q[1:0], araddr_q[1:0]};

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs)     w_next = W_HAVE_A;
        else if (w_hs) w_next = W_HAVE_D;
      end
      W_HAVE_A: if (!Wready)  w_next = W_RESP;
      W_HAVE_D: if (!AWready) w_next = W_RESP;
      W_RESP:   if (Bready)   w_next = W_IDLE;
      default:  w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ARvalid) r_next = R_FETCH;
      R_FETCH: r_next = R_RESP;
      R_RESP:  if (Rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      AWready  <= 1'b1;
      Wready   <= 1'b1;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      araddr_q <= '0;
      Rdata    <= '0;
      err      <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (aw_hs) begin
        awaddr_q <= AWdata;
        AWready  <= 1'b0;
      end
      if (w_hs) begin
        wdata_q <= Wdata;
        wstrb_q <= Wstrb;
        Wready  <= 1'b0;
      end
      if (b_hs) begin
        AWready <= 1'b1;
        Wready  <= 1'b1;
      end
      if (ar_hs) araddr_q <= ARdata;
      if (rd_fetch) Rdata <= rd_in_range ? mem[rd_idx] : '0;
      err <= (wr_commit && !wr_in_range) || (rd_fetch && !rd_in_range);
    end
  end

  // Same-edge read of a committing word sees the old contents (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_commit && wr_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_sram_slave.sv
// Randomised bench for axi4lite_sram_slave with a transaction-level memory model checked every cycle.
module tb_axi4lite_sram_slave;
  localparam logic [31:0] BASE  = 32'h0000_4000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] AWdata, Wdata, ARdata, Rdata;
  logic        AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
  logic        ARvalid, ARready, Rvalid, Rready, err;
  logic [2:0]  AWprot, ARprot;
  logic [3:0]  Wstrb;

  always #5 clk = ~clk;

  axi4lite_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .AWdata(AWdata), .AWvalid(AWvalid), .AWready(AWready), .AWprot(AWprot),
    .Wdata(Wdata), .Wstrb(Wstrb), .Wvalid(Wvalid), .Wready(Wready),
    .Bvalid(Bvalid), .Bready(Bready),
    .ARdata(ARdata), .ARvalid(ARvalid), .ARready(ARready), .ARprot(ARprot),
    .Rdata(Rdata), .Rvalid(Rvalid), .Rready(Rready), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;

  // Model: memory image plus what each channel currently holds.
  logic [31:0] mdl_mem [DEPTH];
  logic        m_ha, m_hd, m_bvalid, m_har, m_fetch, m_rvalid, m_err;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_in(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  // Sampled at negedge: compare, then predict what holds after the coming posedge.
  task automatic monitor();
    logic       nerr;
    logic [3:0] idx;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk1("rst_AWready", AWready, 1'b1);
        chk1("rst_Wready", Wready, 1'b1);
        chk1("rst_ARready", ARready, 1'b1);
        chk1("rst_Bvalid", Bvalid, 1'b0);
        chk1("rst_Rvalid", Rvalid, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_Rdata", Rdata, 32'h0);
        m_ha = 0; m_hd = 0; m_bvalid = 0; m_har = 0; m_fetch = 0; m_rvalid = 0;
        m_err = 0; m_rdata = 0;
      end else begin
        chk1("AWready", AWready, !m_ha);
        chk1("Wready", Wready, !m_hd);
        chk1("ARready", ARready, !m_har);
        chk1("Bvalid", Bvalid, m_bvalid);
        chk1("Rvalid", Rvalid, m_rvalid);
        chk1("err", err, m_err);
        chk("Rdata", Rdata, m_rdata);
        if (err === 1'b1) err_cnt++;
        nerr = 1'b0;
        if (m_fetch) begin
          idx = 4'((m_araddr - BASE) >> 2);
          m_rdata = m_in(m_araddr) ? mdl_mem[idx] : 32'h0;
          nerr = !m_in(m_araddr);
          m_rvalid = 1; m_fetch = 0;
        end else if (m_rvalid && Rready) begin
          m_rvalid = 0; m_har = 0;
        end else if (!m_har && ARvalid) begin
          m_har = 1; m_fetch = 1; m_araddr = ARdata;
        end
        if (m_ha && m_hd && !m_bvalid) begin
          if (m_in(m_awaddr)) begin
            idx = 4'((m_awaddr - BASE) >> 2);
            for (int i = 0; i < 4; i++)
              if (m_wstrb[i]) mdl_mem[idx][8*i +: 8] = m_wdata[8*i +: 8];
          end else begin
            nerr = 1'b1;
          end
          m_bvalid = 1;
        end else if (m_bvalid && Bready) begin
          m_bvalid = 0; m_ha = 0; m_hd = 0;
        end else begin
          if (!m_ha && AWvalid) begin m_ha = 1; m_awaddr = AWdata; end
          if (!m_hd && Wvalid) begin m_hd = 1; m_wdata = Wdata; m_wstrb = Wstrb; end
        end
        m_err = nerr;
      end
    end
  endtask

  // All driver tasks start and end at posedge+1.
  task automatic send_aw(input logic [31:0] a, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    AWdata = a; AWprot = 3'($urandom); AWvalid = 1'b1;
    for (int n = 0; n <= 200; n++) begin
      @(negedge clk);
      if (AWready) break;
      if (n == 200) chk1("aw_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    @(posedge clk); #1; AWvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    Wdata = d; Wstrb = s; Wvalid = 1'b1;
    for (int n = 0; n <= 200; n++) begin
      @(negedge clk);
      if (Wready) break;
      if (n == 200) chk1("w_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    @(posedge clk); #1; Wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    ARdata = a; ARprot = 3'($urandom); ARvalid = 1'b1;
    for (int n = 0; n <= 200; n++) begin
      @(negedge clk);
      if (ARready) break;
      if (n == 200) chk1("ar_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    @(posedge clk); #1; ARvalid = 1'b0;
  endtask

  task automatic wait_b(input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    Bready = 1'b1;
    for (int n = 0; n <= 200; n++) begin
      @(negedge clk);
      if (Bvalid) break;
      if (n == 200) chk1("b_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    @(posedge clk); #1; Bready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, input int bd);
    fork
      send_aw(a, awd);
      send_w(d, s, wd);
    join
    wait_b(bd);
  endtask

  task automatic do_read(input logic [31:0] a, input int ard, input int rd_dly,
                         output logic [31:0] rd);
    rd = 'x;
    send_ar(a, ard);
    repeat (rd_dly) begin @(posedge clk); #1; end
    Rready = 1'b1;
    for (int n = 0; n <= 200; n++) begin
      @(negedge clk);
      if (Rvalid) begin rd = Rdata; break; end
      if (n == 200) chk1("r_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    @(posedge clk); #1; Rready = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned p;
    p = $urandom_range(0, 19);
    if (p == 0) return BASE - 32'd4 + 32'($urandom_range(0, 3));
    if (p == 1) return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
    if (p == 2) return 32'h8000_0000 + BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
    return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
  endfunction

  initial begin
    logic [31:0] rd;
    int e0;
    rstn = 1'b0;
    AWdata = 0; AWvalid = 0; AWprot = 0; Wdata = 0; Wstrb = 0; Wvalid = 0; Bready = 0;
    ARdata = 0; ARvalid = 0; ARprot = 0; Rready = 0;
    fork
      monitor();
      begin
        #300000;
        $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
      end
    join_none
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Known image: word i = C0DE000i, word 8 cleared for the collision case.
    for (int i = 0; i < DEPTH; i++)
      do_write(BASE + 32'(4 * i), (i == 8) ? 32'h0 : (32'hC0DE_0000 | 32'(i)), 4'hF, 0, 0, 0);

    // Same-edge AW+W: Bvalid one edge later, readies back after the B handshake.
    AWdata = BASE + 32'h10; AWvalid = 1; Wdata = 32'hDEAD_BEEF; Wstrb = 4'hF; Wvalid = 1; Bready = 1;
    @(posedge clk); #1; AWvalid = 0; Wvalid = 0;
    chk1("t1_bvalid_e", Bvalid, 1'b0);
    chk1("t1_awready_e", AWready, 1'b0);
    chk1("t1_wready_e", Wready, 1'b0);
    @(posedge clk); #1;
    chk1("t1_bvalid_e1", Bvalid, 1'b1);
    @(posedge clk); #1; Bready = 0;
    chk1("t1_bvalid_f", Bvalid, 1'b0);
    chk1("t1_awready_f", AWready, 1'b1);
    chk1("t1_wready_f", Wready, 1'b1);
    do_read(BASE + 32'h10, 0, 0, rd);
    chk("t1_readback", rd, 32'hDEAD_BEEF);

    // W three cycles ahead of AW, partial strobe.
    fork
      send_w(32'h1122_3344, 4'b0101, 0);
      send_aw(BASE + 32'h10, 3);
    join
    wait_b(0);
    do_read(BASE + 32'h10, 0, 0, rd);
    chk("t2_strobe", rd, 32'hDE22_BE44);

    // Read response held off by Rready; a competing ARvalid must be ignored.
    send_ar(BASE + 32'h10, 0);
    @(posedge clk); #1;
    ARdata = BASE; ARvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk1("t3_rvalid_hold", Rvalid, 1'b1);
      chk("t3_rdata_hold", Rdata, 32'hDE22_BE44);
      chk1("t3_arready_hold", ARready, 1'b0);
      @(posedge clk); #1;
    end
    ARvalid = 1'b0; Rready = 1'b1;
    @(posedge clk); #1; Rready = 1'b0;
    chk1("t3_arready_back", ARready, 1'b1);
    chk1("t3_rvalid_drop", Rvalid, 1'b0);
    chk("t3_rdata_keep", Rdata, 32'hDE22_BE44);

    // Out-of-range write and read.
    e0 = err_cnt;
    do_write(BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    chk("t4_wr_err_pulses", 32'(err_cnt - e0), 32'd1);
    do_read(BASE + 32'(4 * (DEPTH - 1)), 0, 0, rd);
    chk("t4_last_word", rd, 32'hC0DE_000F);
    e0 = err_cnt;
    do_read(BASE + 32'(4 * DEPTH), 0, 0, rd);
    chk("t4_oob_rdata", rd, 32'h0);
    chk("t4_rd_err_pulses", 32'(err_cnt - e0), 32'd1);

    // Write commit and read fetch of the same word on the same edge.
    fork
      do_write(BASE + 32'h20, 32'hAAAA_5555, 4'hF, 0, 0, 0);
      do_read(BASE + 32'h20, 0, 0, rd);
    join
    chk("t5_collide_old", rd, 32'h0);
    do_read(BASE + 32'h20, 0, 0, rd);
    chk("t5_collide_new", rd, 32'hAAAA_5555);

    // Reset after the AW handshake only: transaction dropped, outputs reset at once.
    send_aw(BASE + 32'h30, 0);
    rstn = 1'b0;
    #1;
    chk1("t6_awready", AWready, 1'b1);
    chk1("t6_wready", Wready, 1'b1);
    chk1("t6_arready", ARready, 1'b1);
    chk1("t6_bvalid", Bvalid, 1'b0);
    chk1("t6_rvalid", Rvalid, 1'b0);
    chk("t6_rdata", Rdata, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1; rstn = 1'b1;
    do_read(BASE + 32'h30, 0, 0, rd);
    chk("t6_unchanged", rd, 32'hC0DE_000C);

    // Concurrent random traffic; the monitor checks every cycle.
    fork
      for (int k = 0; k < 120; k++)
        do_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      begin
        logic [31:0] rr;
        for (int k = 0; k < 120; k++)
          do_read(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3), rr);
      end
    join

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4lite_sram_slave.md
Name: axi4lite_sram_slave

Overview:
AXI4-Lite responder (slave) backed by a word-organised on-chip SRAM. It is the memory end of the core's AXI4-Lite master port and serves both instruction fetches and load/store traffic. Port names mirror the core's bus signals: AWdata/ARdata carry addresses, and there is no BRESP/RRESP. Read and write channels operate independently, one outstanding transaction per channel.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4*DEPTH aligned
DEPTH, 1024, number of 32-bit words; power of two, 16..65536

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset, asynchronous, active-low
AWdata  input  32  write address, byte address
AWvalid  input  1  write address valid
AWready  output  1  write address ready
AWprot  input  3  accepted and ignored
Wdata  input  32  write data
Wstrb  input  4  byte enables; bit i drives byte lane [8i+7:8i]
Wvalid  input  1  write data valid
Wready  output  1  write data ready
Bvalid  output  1  write response valid
Bready  input  1  write response ready
ARdata  input  32  read address, byte address
ARvalid  input  1  read address valid
ARready  output  1  read address ready
ARprot  input  3  accepted and ignored
Rdata  output  32  read data
Rvalid  output  1  read data valid
Rready  input  1  read data ready
err  output  1  one-cycle pulse on an out-of-range access, read or write

Behaviour:
- Reset values: AWready=1, Wready=1, ARready=1, Bvalid=0, Rvalid=0, Rdata=0, err=0. SRAM contents are not reset.
- Decode: in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH. Word index = (addr-BASE_ADDR)>>2. addr[1:0] ignored.
- Write FSM states: W_IDLE (neither captured), W_HAVE_A, W_HAVE_D, W_RESP.
  - AWvalid&AWready at edge E: latch address; AWready<=0.
  - Wvalid&Wready at edge E: latch Wdata/Wstrb; Wready<=0.
  - Either handshake may come first, or both on the same edge.
  - At the first edge after both are latched: write strobed bytes to SRAM, Bvalid<=1, state W_RESP.
  - Result: same-edge AW+W at E gives Bvalid high after E+1.
  - Bvalid holds until Bvalid&Bready at edge F. At F: Bvalid<=0, AWready<=1, Wready<=1, state W_IDLE.
  - Wstrb=4'b0000: no SRAM change; response is still issued.
  - Out of range: SRAM untouched; Bvalid issued normally; err=1 for the cycle Bvalid rises.
- Read FSM states: R_IDLE, R_FETCH, R_RESP.
  - ARvalid&ARready at edge E: latch address; ARready<=0; state R_FETCH.
  - Edge E+1: Rdata<=SRAM[word], or 32'h0 if out of range (err=1 that cycle); Rvalid<=1; state R_RESP.
  - Rdata stays stable while Rvalid=1.
  - Rvalid&Rready at edge F: Rvalid<=0, ARready<=1, state R_IDLE. Rdata keeps its last value.
- Collision: when the write commit and read fetch hit the same word on the same edge, Rdata returns the old word (read-before-write).
- Channels never stall each other. Master holding valid while ready=0 has no effect.
- Backpressure: Bready/Rready held low keeps the response pending indefinitely; no new transaction is accepted on that channel.
- Reset mid-transaction (rstn low at any time): outputs go to reset values immediately and latched transactions are dropped. A write not yet committed is never performed.
- Maximum throughput: one write per 3 cycles and one read per 3 cycles when Bready/Rready are held high.

Test Plan:
- Reset, then write AW=0x10, W=0xDEADBEEF, Wstrb=4'hF on the same edge, Bready=1 -> Bvalid rises one edge later, then AWready/Wready rise; read 0x10 -> Rvalid one edge after AR handshake, Rdata=0xDEADBEEF.
- W handshake 3 cycles before AW (Wdata=0x11223344, Wstrb=4'b0101, addr 0x10 holding 0xDEADBEEF) -> no Bvalid until AW accepted; readback 0xDE22BE44.
- Hold Rready=0 for 5 cycles after a read of 0x10 -> Rvalid and Rdata stable throughout, ARready=0, new ARvalid ignored; Rready=1 -> ARready=1 next edge.
- Write to BASE_ADDR+4*DEPTH with 0xFFFFFFFF -> Bvalid issued, err pulses one cycle, no word changes (word DEPTH-1 readback unchanged); read of the same address -> Rdata=0, err pulse.
- Same-edge commit (0x20, 0xAAAA5555, old value 0x0) and read fetch of 0x20 -> Rdata=0x0; a subsequent read returns 0xAAAA5555.
- Assert rstn=0 after the AW handshake only, release, read the target word -> unchanged; AWready=Wready=ARready=1 and Bvalid=Rvalid=0 immediately on rstn fall.
